// File: rtl/hud_pkg.sv
// Shared definitions for the HUD lives indicator.
//   - hud_state_t : lives FSM encoding (ALIVE / BLINK / GAME_OVER)
//   - HEART_COLS  : number of BW-wide columns in a heart glyph
//   - col_top_units / col_bot_units : vertical extent of each column,
//     in multiples of BW measured from the heart's top edge
//   - HEART_RGB_DEF / BLACK_RGB : colour constants
package hud_pkg;

  typedef enum logic [1:0] {
    ALIVE     = 2'd0,
    BLINK     = 2'd1,
    GAME_OVER = 2'd2
  } hud_state_t;

  localparam int PIX_W      = 10;
  localparam int HEART_COLS = 5;

  localparam logic [2:0] HEART_RGB_DEF = 3'b100;
  localparam logic [2:0] BLACK_RGB     = 3'b000;

  // Heart silhouette: the two lobes (columns 1 and 3) start at the top,
  // the outer columns are shorter, the centre column forms the point.
  function automatic int col_top_units(input int c);
    return (c == 1 || c == 3) ? 0 : 1;
  endfunction

  function automatic int col_bot_units(input int c);
    int r;
    case (c)
      1, 3:    r = 4;
      2:       r = 5;
      default: r = 3;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/generador_vidas_param_if.sv
// Pixel bus between the video timing / RGB multiplexer and a sprite
// generator.
//   video_on, pix_x, pix_y : scan position, driven by the master
//   graph_on, graph_rgb    : generator hit flag and colour, driven by the slave
interface generador_vidas_param_if;
  import hud_pkg::*;

  logic             video_on;
  logic [PIX_W-1:0] pix_x;
  logic [PIX_W-1:0] pix_y;
  logic             graph_on;
  logic [2:0]       graph_rgb;

  modport master (
    output video_on,
    output pix_x,
    output pix_y,
    input  graph_on,
    input  graph_rgb
  );

  modport slave (
    input  video_on,
    input  pix_x,
    input  pix_y,
    output graph_on,
    output graph_rgb
  );

endinterface

// File: rtl/heart_glyph.sv
// Combinational hit test for a single heart glyph.
//   HX, HY   : top-left origin of the heart (pixels)
//   BW       : column width and vertical unit (pixels)
//   pix_x/y  : current scan position
//   in_heart : pixel lies inside the heart silhouette
// All bounds are inclusive, unsigned, 10 bits wide and fixed at elaboration.
module heart_glyph
  import hud_pkg::*;
#(
  parameter int HX = 430,
  parameter int HY = 420,
  parameter int BW = 5
) (
  input  logic [PIX_W-1:0] pix_x,
  input  logic [PIX_W-1:0] pix_y,
  output logic             in_heart
);

  logic [HEART_COLS-1:0] col_hit;

  generate
    for (genvar gi = 0; gi < HEART_COLS; gi++) begin : g_col
      localparam logic [PIX_W-1:0] X_LO = PIX_W'(HX + gi * BW);
      localparam logic [PIX_W-1:0] X_HI = PIX_W'(HX + (gi + 1) * BW);
      localparam logic [PIX_W-1:0] Y_LO = PIX_W'(HY + col_top_units(gi) * BW);
      localparam logic [PIX_W-1:0] Y_HI = PIX_W'(HY + col_bot_units(gi) * BW);

      assign col_hit[gi] = (pix_x >= X_LO) && (pix_x <= X_HI) &&
                           (pix_y >= Y_LO) && (pix_y <= Y_HI);
    end
  endgenerate

  assign in_heart = |col_hit;

endmodule

// File: rtl/generador_vidas_param.sv
// Lives indicator for the maze HUD.
// Draws N_LIVES hearts in a row and owns the lives counter. A one-cycle
// hit pulse costs one life and opens an invulnerability window of
// BLINK_FRAMES frames during which the lost heart blinks; when the window
// closes with no lives left, game_over is raised until restart.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   refr_tick    : one pulse per frame
//   hit          : collision pulse
//   restart      : new-game pulse (highest priority)
//   pix          : pixel bus (slave side), graph_on/graph_rgb are
//                  combinational from the scan position and registered state
//   lives        : remaining lives
//   blinking     : invulnerability window active (registered)
//   game_over    : no lives and blink finished (registered)
module generador_vidas_param
  import hud_pkg::*;
#(
  parameter int         N_LIVES      = 3,
  parameter int         X0           = 430,
  parameter int         Y0           = 420,
  parameter int         PITCH        = 30,
  parameter int         BW           = 5,
  parameter int         BLINK_FRAMES = 32,
  parameter int         BLINK_HALF   = 4,
  parameter logic [2:0] HEART_RGB    = HEART_RGB_DEF,
  localparam int        LW           = $clog2(N_LIVES + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 refr_tick,
  input  logic                 hit,
  input  logic                 restart,
  generador_vidas_param_if.slave pix,
  output logic [LW-1:0]        lives,
  output logic                 blinking,
  output logic                 game_over
);

  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW:0] FRAMES_END = (CW + 1)'(BLINK_FRAMES);
  localparam logic [CW:0] HALF_LEN   = (CW + 1)'(BLINK_HALF);

  hud_state_t    state_reg;
  logic [LW-1:0] lives_reg;
  logic [CW-1:0] cnt_reg;
  logic          phase_reg;
  logic          blinking_reg;
  logic          game_over_reg;

  // One bit wider than the counter so the end-of-window compare sees the
  // full value counter+1 without wrapping.
  logic [CW:0] cnt_inc;
  logic        phase_flip;

  assign cnt_inc    = {1'b0, cnt_reg} + 1'b1;
  assign phase_flip = ((cnt_inc % HALF_LEN) == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ALIVE;
      lives_reg     <= LW'(N_LIVES);
      cnt_reg       <= '0;
      phase_reg     <= 1'b1;
      blinking_reg  <= 1'b0;
      game_over_reg <= 1'b0;
    end else if (restart) begin
      // restart wins over hit and refr_tick in every state
      state_reg     <= ALIVE;
      lives_reg     <= LW'(N_LIVES);
      cnt_reg       <= '0;
      phase_reg     <= 1'b1;
      blinking_reg  <= 1'b0;
      game_over_reg <= 1'b0;
    end else begin
      case (state_reg)
        ALIVE: begin
          // A refr_tick arriving with the hit is deliberately not counted:
          // the window starts from zero on the next frame.
          if (hit && (lives_reg != '0)) begin
            lives_reg    <= lives_reg - 1'b1;
            cnt_reg      <= '0;
            phase_reg    <= 1'b1;
            state_reg    <= BLINK;
            blinking_reg <= 1'b1;
          end
        end
        BLINK: begin
          if (refr_tick) begin
            if (cnt_inc == FRAMES_END) begin
              cnt_reg      <= '0;
              phase_reg    <= 1'b1;
              blinking_reg <= 1'b0;
              if (lives_reg == '0) begin
                state_reg     <= GAME_OVER;
                game_over_reg <= 1'b1;
              end else begin
                state_reg <= ALIVE;
              end
            end else begin
              cnt_reg <= cnt_inc[CW-1:0];
              if (phase_flip) begin
                phase_reg <= ~phase_reg;
              end
            end
          end
        end
        GAME_OVER: begin
          game_over_reg <= 1'b1;
        end
        default: begin
          // Unused encoding: fall back to a safe playing state.
          state_reg     <= ALIVE;
          blinking_reg  <= 1'b0;
          game_over_reg <= 1'b0;
        end
      endcase
    end
  end

  assign lives     = lives_reg;
  assign blinking  = blinking_reg;
  assign game_over = game_over_reg;

  // ---------------- pixel path ----------------
  logic [N_LIVES-1:0] in_heart;
  logic [N_LIVES-1:0] visible;

  generate
    for (genvar gi = 0; gi < N_LIVES; gi++) begin : g_heart
      heart_glyph #(
        .HX (X0 + gi * PITCH),
        .HY (Y0),
        .BW (BW)
      ) u_heart (
        .pix_x    (pix.pix_x),
        .pix_y    (pix.pix_y),
        .in_heart (in_heart[gi])
      );

      // Hearts below the lives count are lit; the heart just lost is lit
      // only during the "on" half of each blink period.
      assign visible[gi] =
          ((state_reg != GAME_OVER) && (LW'(gi) < lives_reg)) ||
          ((state_reg == BLINK) && (LW'(gi) == lives_reg) && phase_reg);
    end
  endgenerate

  assign pix.graph_on  = pix.video_on && (|(in_heart & visible));
  assign pix.graph_rgb = pix.graph_on ? HEART_RGB : BLACK_RGB;

endmodule

// File: tb/tb_generador_vidas_param.sv
module tb_generador_vidas_param;
  import hud_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       refr_tick = 1'b0;
  logic       hit = 1'b0;
  logic       restart = 1'b0;
  logic [1:0] lives;
  logic       blinking;
  logic       game_over;

  generador_vidas_param_if vif ();

  generador_vidas_param dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .refr_tick (refr_tick),
    .hit       (hit),
    .restart   (restart),
    .pix       (vif.slave),
    .lives     (lives),
    .blinking  (blinking),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  typedef enum int {S_LIVES, S_BLINK, S_GOVER, S_GON, S_RGB} sig_e;
  typedef struct {
    string       tag;
    sig_e        sel;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] observe(input sig_e s);
    logic [31:0] r;
    case (s)
      S_LIVES: r = {30'd0, lives};
      S_BLINK: r = {31'd0, blinking};
      S_GOVER: r = {31'd0, game_over};
      S_GON:   r = {31'd0, vif.graph_on};
      default: r = {29'd0, vif.graph_rgb};
    endcase
    return r;
  endfunction

  task automatic expect_val(input string tag, input sig_e s, input logic [31:0] e);
    sb.push_back('{tag: tag, sel: s, exp: e});
  endtask

  task automatic check_all();
    sb_item_t    it;
    logic [31:0] o;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      o  = observe(it.sel);
      checks++;
      assert (o === it.exp) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", it.tag, o, it.exp);
      end
      $display("check %-14s observed=%0h expected=%0h", it.tag, o, it.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_hit();
    hit = 1'b1; step(); hit = 1'b0;
  endtask

  task automatic pulse_refr();
    refr_tick = 1'b1; step(); refr_tick = 1'b0;
  endtask

  task automatic pulse_restart();
    restart = 1'b1; step(); restart = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      pulse_refr();
      step();
    end
  endtask

  task automatic set_pix(input int x, input int y);
    vif.pix_x = 10'(x);
    vif.pix_y = 10'(y);
    #1;
  endtask

  initial begin
    vif.video_on = 1'b1;
    vif.pix_x    = '0;
    vif.pix_y    = '0;

    // reset state
    step(); step();
    expect_val("rst_lives", S_LIVES, 3);
    expect_val("rst_blink", S_BLINK, 0);
    expect_val("rst_gover", S_GOVER, 0);
    check_all();
    reset_n = 1'b1;
    step();

    // heart 0 geometry
    set_pix(432, 430);
    expect_val("h0_lobe_on", S_GON, 1);
    expect_val("h0_lobe_rgb", S_RGB, 3'b100);
    check_all();
    set_pix(432, 441);
    expect_val("h0_below_off", S_GON, 0);
    check_all();
    set_pix(442, 445);
    expect_val("h0_point_on", S_GON, 1);
    expect_val("lives3", S_LIVES, 3);
    check_all();

    // first hit: heart 2 blinks for 32 frames, extra hits ignored
    pulse_hit();
    expect_val("hit1_lives", S_LIVES, 2);
    expect_val("hit1_blink", S_BLINK, 1);
    check_all();
    set_pix(502, 430);
    for (int j = 0; j < 32; j++) begin
      expect_val($sformatf("blink_ph%0d", j), S_GON, ((j / 4) % 2 == 0) ? 1 : 0);
      expect_val($sformatf("blinking%0d", j), S_BLINK, 1);
      check_all();
      if (j == 5 || j == 10) begin
        pulse_hit();
        expect_val("hit_in_blink", S_LIVES, 2);
        check_all();
      end
      pulse_refr();
    end
    expect_val("blink1_end", S_BLINK, 0);
    expect_val("h2_dark", S_GON, 0);
    expect_val("lives2_hold", S_LIVES, 2);
    check_all();

    // second hit, full window
    pulse_hit();
    expect_val("hit2_lives", S_LIVES, 1);
    check_all();
    set_pix(472, 430);
    run_ticks(32);
    expect_val("blink2_end", S_BLINK, 0);
    expect_val("h1_dark", S_GON, 0);
    check_all();

    // last hit together with refr_tick: that frame is not counted
    hit = 1'b1; refr_tick = 1'b1; step(); hit = 1'b0; refr_tick = 1'b0;
    expect_val("hit3_lives", S_LIVES, 0);
    expect_val("hit3_blink", S_BLINK, 1);
    check_all();
    run_ticks(31);
    expect_val("t31_blink", S_BLINK, 1);
    expect_val("t31_gover", S_GOVER, 0);
    check_all();
    pulse_refr();
    expect_val("gover_set", S_GOVER, 1);
    expect_val("gover_blink", S_BLINK, 0);
    check_all();
    set_pix(432, 430);
    expect_val("gover_h0_off", S_GON, 0);
    check_all();
    set_pix(442, 445);
    expect_val("gover_pt_off", S_GON, 0);
    check_all();
    pulse_hit();
    expect_val("gover_hit_lv", S_LIVES, 0);
    expect_val("gover_hit_go", S_GOVER, 1);
    check_all();
    pulse_restart();
    expect_val("restart_lives", S_LIVES, 3);
    expect_val("restart_gover", S_GOVER, 0);
    check_all();
    set_pix(432, 430);
    expect_val("restart_h0", S_GON, 1);
    check_all();

    // restart and hit in the same cycle from lives=2
    pulse_hit();
    expect_val("pre_rh_lives", S_LIVES, 2);
    check_all();
    hit = 1'b1; restart = 1'b1; step(); hit = 1'b0; restart = 1'b0;
    expect_val("rh_lives", S_LIVES, 3);
    expect_val("rh_blink", S_BLINK, 0);
    check_all();

    // video_on gating
    vif.video_on = 1'b0; #1;
    expect_val("voff_gon", S_GON, 0);
    expect_val("voff_rgb", S_RGB, 3'b000);
    check_all();
    vif.video_on = 1'b1; #1;
    expect_val("von_rgb", S_RGB, 3'b100);
    check_all();

    // asynchronous reset mid-blink, checked before any clock edge
    pulse_hit();
    run_ticks(3);
    expect_val("pre_arst_blk", S_BLINK, 1);
    check_all();
    #1 reset_n = 1'b0;
    #1;
    expect_val("arst_lives", S_LIVES, 3);
    expect_val("arst_blink", S_BLINK, 0);
    expect_val("arst_gover", S_GOVER, 0);
    check_all();
    reset_n = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
